// File: rtl/led_pkg.sv
// Shared mode encoding and button roles for the board LED driver.
package led_pkg;

  // 2'd3 is not a legal mode; the mode FSM steers it back to MODE_MUX.
  typedef enum logic [1:0] {
    MODE_MUX   = 2'd0,
    MODE_CHASE = 2'd1,
    MODE_BLINK = 2'd2
  } mode_t;

  localparam int unsigned BTN_MODE = 0;
  localparam int unsigned BTN_DIR  = 1;
  localparam int unsigned BTN_RUN  = 2;

endpackage

// File: rtl/led_ctrl_btn_debounce.sv
// Single push-button conditioner: 2-FF synchroniser, stability counter,
// debounced level and a one-cycle press pulse on each accepted 0->1 edge.
module btn_debounce #(
  parameter int unsigned DEB_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then accept a new level after DEB_CYC consecutive samples
  // that differ from the current level; any bounce back restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYC - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_ctrl.sv
// Board LED driver: switch mux, rotating chaser or blink, selected by
// debounced push-buttons. ledr is registered.
module led_ctrl
  import led_pkg::*;
#(
  parameter int unsigned LED_W   = 16,
  parameter int unsigned SW_W    = 8,
  parameter int unsigned BTN_W   = 5,
  parameter int unsigned DIV     = 5000000,
  parameter int unsigned DEB_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BTN_W-1:0] btn,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] ledr
);

  localparam int unsigned CNT_W = $clog2(DIV + 1);

  logic [BTN_W-1:0] btn_level;
  logic [BTN_W-1:0] btn_press;
  logic             unused_btn;

  mode_t            mode;
  mode_t            mode_d;
  logic             mode_chg;
  logic             dir;
  logic             run;
  logic [LED_W-1:0] pat;
  logic [LED_W-1:0] pat_rot;
  logic             phase;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [LED_W-1:0] mask;
  logic [LED_W-1:0] ledr_d;

  for (genvar i = 0; i < BTN_W; i++) begin : g_deb
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn[i]),
      .level (btn_level[i]),
      .press (btn_press[i])
    );
  end

  // Levels and buttons above BTN_RUN carry no function.
  assign unused_btn = ^{btn_level, btn_press};

  // Tick on the last count of a running, non-mux animation period.
  assign tick = run && (mode != MODE_MUX) && (cnt == CNT_W'(DIV - 1));

  // Mode sequencing on btn[BTN_MODE]; illegal encodings fall back to mux.
  always_comb begin
    mode_d = mode;
    case (mode)
      MODE_MUX:   if (btn_press[BTN_MODE]) mode_d = MODE_CHASE;
      MODE_CHASE: if (btn_press[BTN_MODE]) mode_d = MODE_BLINK;
      MODE_BLINK: if (btn_press[BTN_MODE]) mode_d = MODE_MUX;
      default:    mode_d = MODE_MUX;
    endcase
  end

  assign mode_chg = (mode_d != mode);

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) mode <= MODE_MUX;
    else     mode <= mode_d;
  end

  // One-step rotation of the chaser pattern in the current direction.
  always_comb begin
    pat_rot = dir ? {pat[0], pat[LED_W-1:1]} : {pat[LED_W-2:0], pat[LED_W-1]};
  end

  // Animation state: a mode change reloads and overrides a same-cycle tick;
  // a same-cycle run toggle only affects later cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir   <= 1'b0;
      run   <= 1'b1;
      pat   <= LED_W'(1);
      phase <= 1'b0;
      cnt   <= '0;
    end else begin
      if (btn_press[BTN_DIR]) dir <= ~dir;
      if (btn_press[BTN_RUN]) run <= ~run;
      if (mode_chg) begin
        cnt   <= '0;
        pat   <= LED_W'(1);
        phase <= 1'b0;
      end else if (run && (mode != MODE_MUX)) begin
        cnt <= tick ? '0 : cnt + CNT_W'(1);
        if (tick && (mode == MODE_CHASE)) pat   <= pat_rot;
        if (tick && (mode == MODE_BLINK)) phase <= ~phase;
      end
    end
  end

  // LED source selection; the blink mask repeats sw across all LEDs.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < LED_W; i++) mask[i] = sw[i % SW_W];
    ledr_d = '0;
    case (mode)
      MODE_MUX:   ledr_d[0] = sw[2] ? sw[1] : sw[0];
      MODE_CHASE: ledr_d = pat;
      MODE_BLINK: ledr_d = phase ? mask : '0;
      default:    ledr_d = '0;
    endcase
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) ledr <= '0;
    else     ledr <= ledr_d;
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl (LED_W=8, SW_W=8, BTN_W=5, DIV=4, DEB_CYC=2).
// A button set after edge k gives a press after edge k+4 and the new mode
// after edge k+5; ledr shows a state change one edge after it happens.
module tb_led_ctrl;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic [7:0] sw;
  logic [7:0] ledr;

  int n_cmp = 0;
  int n_err = 0;

  led_ctrl #(
    .LED_W(8), .SW_W(8), .BTN_W(5), .DIV(4), .DEB_CYC(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .sw   (sw),
    .ledr (ledr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; btn = '0; sw = '0;
    step(2);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL reset_ledr: got %h want %h", ledr, 8'h00); end
    n_cmp++; if (dut.run !== 1'b1) begin n_err++; $display("FAIL reset_run: got %b want 1", dut.run); end
    rst = 1'b0;
    sw = 8'b011;
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL mux_latency: got %h want %h", ledr, 8'h00); end
    step(1);
    n_cmp++; if (ledr !== 8'h01) begin n_err++; $display("FAIL mux_011: got %h want %h", ledr, 8'h01); end
    sw = 8'b101; step(1);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL mux_101: got %h want %h", ledr, 8'h00); end
    sw = 8'b110; step(1);
    n_cmp++; if (ledr !== 8'h01) begin n_err++; $display("FAIL mux_110: got %h want %h", ledr, 8'h01); end
    sw = 8'h00; step(1);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL mux_000: got %h want %h", ledr, 8'h00); end
  endtask

  task automatic test_debounce;
    btn[0] = 1'b1; step(1);
    btn[0] = 1'b0; step(8);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL glitch: got %h want %h", ledr, 8'h00); end
    btn[0] = 1'b1; step(5);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL press_early: got %h want %h", ledr, 8'h00); end
    step(1);
    n_cmp++; if (ledr !== 8'h01) begin n_err++; $display("FAIL press_chase: got %h want %h", ledr, 8'h01); end
    step(4);
    n_cmp++; if (ledr !== 8'h02) begin n_err++; $display("FAIL first_tick: got %h want %h", ledr, 8'h02); end
    btn[0] = 1'b0;
  endtask

  task automatic test_chase;
    logic [7:0] seq [7];
    logic [7:0] prev;
    seq = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    prev = 8'h02;
    for (int k = 0; k < 7; k++) begin
      step(3);
      n_cmp++; if (ledr !== prev) begin n_err++; $display("FAIL chase_hold%0d: got %h want %h", k, ledr, prev); end
      step(1);
      n_cmp++; if (ledr !== seq[k]) begin n_err++; $display("FAIL chase_step%0d: got %h want %h", k, ledr, seq[k]); end
      prev = seq[k];
    end
    btn[1] = 1'b1; step(4);
    n_cmp++; if (ledr !== 8'h02) begin n_err++; $display("FAIL dir_before: got %h want %h", ledr, 8'h02); end
    btn[1] = 1'b0; step(4);
    n_cmp++; if (ledr !== 8'h01) begin n_err++; $display("FAIL dir_right: got %h want %h", ledr, 8'h01); end
    step(4);
    n_cmp++; if (ledr !== 8'h80) begin n_err++; $display("FAIL dir_wrap: got %h want %h", ledr, 8'h80); end
    step(4);
    n_cmp++; if (ledr !== 8'h40) begin n_err++; $display("FAIL dir_80_40: got %h want %h", ledr, 8'h40); end
  endtask

  task automatic test_blink;
    logic [7:0] seq [3];
    logic [7:0] prev;
    seq = '{8'hA5, 8'h00, 8'hA5};
    sw = 8'hA5; btn[0] = 1'b1; step(4);
    n_cmp++; if (ledr !== 8'h20) begin n_err++; $display("FAIL chase_before_blink: got %h want %h", ledr, 8'h20); end
    btn[0] = 1'b0; step(2);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL blink_enter: got %h want %h", ledr, 8'h00); end
    prev = 8'h00;
    for (int k = 0; k < 3; k++) begin
      step(3);
      n_cmp++; if (ledr !== prev) begin n_err++; $display("FAIL blink_hold%0d: got %h want %h", k, ledr, prev); end
      step(1);
      n_cmp++; if (ledr !== seq[k]) begin n_err++; $display("FAIL blink_step%0d: got %h want %h", k, ledr, seq[k]); end
      prev = seq[k];
    end
    btn[2] = 1'b1; step(4);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL pause_last_tick: got %h want %h", ledr, 8'h00); end
    btn[2] = 1'b0; step(4);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL paused_a: got %h want %h", ledr, 8'h00); end
    step(4);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL paused_b: got %h want %h", ledr, 8'h00); end
    btn[2] = 1'b1; step(4);
    btn[2] = 1'b0; step(3);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL resume_hold: got %h want %h", ledr, 8'h00); end
    step(1);
    n_cmp++; if (ledr !== 8'hA5) begin n_err++; $display("FAIL resume_phase: got %h want %h", ledr, 8'hA5); end
  endtask

  task automatic test_collision;
    sw = 8'h07; btn[0] = 1'b1; btn[1] = 1'b1; step(4);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL coll_blink: got %h want %h", ledr, 8'h00); end
    btn[0] = 1'b0; btn[1] = 1'b0; step(2);
    n_cmp++; if (ledr !== 8'h01) begin n_err++; $display("FAIL coll_mux: got %h want %h", ledr, 8'h01); end
    btn[0] = 1'b1; step(4);
    btn[0] = 1'b0; step(4);
    btn[0] = 1'b1; step(1);
    n_cmp++; if (ledr !== 8'h01) begin n_err++; $display("FAIL coll_chase_start: got %h want %h", ledr, 8'h01); end
    step(1);
    n_cmp++; if (ledr !== 8'h02) begin n_err++; $display("FAIL coll_dir_left: got %h want %h", ledr, 8'h02); end
    step(2);
    btn[0] = 1'b0; step(1);
    n_cmp++; if (ledr !== 8'h02) begin n_err++; $display("FAIL tick_chg_ledr: got %h want %h", ledr, 8'h02); end
    n_cmp++; if (dut.pat !== 8'h01) begin n_err++; $display("FAIL tick_chg_pat: got %h want %h", dut.pat, 8'h01); end
    step(1);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL tick_chg_blink: got %h want %h", ledr, 8'h00); end
    step(3);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL tick_chg_hold: got %h want %h", ledr, 8'h00); end
    step(1);
    n_cmp++; if (ledr !== 8'h07) begin n_err++; $display("FAIL tick_chg_mask: got %h want %h", ledr, 8'h07); end
  endtask

  task automatic test_midop_reset;
    sw = 8'h00; btn[0] = 1'b1; btn[1] = 1'b1; step(4);
    btn[0] = 1'b0; btn[1] = 1'b0; step(4);
    btn[0] = 1'b1; step(4);
    btn[0] = 1'b0; step(16);
    btn[0] = 1'b1; step(2);
    n_cmp++; if (ledr !== 8'h10) begin n_err++; $display("FAIL pre_reset: got %h want %h", ledr, 8'h10); end
    rst = 1'b1; btn[0] = 1'b0; step(1);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL midrst_ledr: got %h want %h", ledr, 8'h00); end
    n_cmp++; if (dut.mode !== MODE_MUX) begin n_err++; $display("FAIL midrst_mode: got %0d want %0d", dut.mode, MODE_MUX); end
    n_cmp++; if (dut.dir !== 1'b0) begin n_err++; $display("FAIL midrst_dir: got %b want 0", dut.dir); end
    n_cmp++; if (dut.run !== 1'b1) begin n_err++; $display("FAIL midrst_run: got %b want 1", dut.run); end
    n_cmp++; if (dut.pat !== 8'h01) begin n_err++; $display("FAIL midrst_pat: got %h want %h", dut.pat, 8'h01); end
    rst = 1'b0; step(6);
    n_cmp++; if (ledr !== 8'h00) begin n_err++; $display("FAIL midrst_deb: got %h want %h", ledr, 8'h00); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_chase();
    test_blink();
    test_collision();
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
